truth_table_scanner: RTL and testbench
======================================

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter: SETTLE, 3, settle cycles per input vector before sampling; legal range 0..15.
REQ-002 Port: clk  input  1  sole clock, rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request a full 8-vector scan; sampled only in IDLE.
REQ-005 Port: abort  input  1  synchronous cancel of a scan in progress.
REQ-006 Port: f_in  input  1  output of the 3-input combinational network under test.
REQ-007 Port: golden  input  8  expected truth table, bit i = expected f for vector i (used only with TT_COMPARE_EN).
REQ-008 Port: a, b, c  output  1 each  registered stimulus to the network; {a,b,c} = vector index, a = MSB.
REQ-009 Port: busy  output  1  high in every state except IDLE.
REQ-010 Port: done  output  1  single-cycle pulse when a scan completes.
REQ-011 Port: table  output  8  captured truth table, bit i = sampled f_in for vector i.
REQ-012 Port: mismatch  output  1  table != golden after the last completed scan (TT_COMPARE_EN only).

Function
REQ-013 States SHALL be IDLE, DRIVE, SETTLE, CAPTURE, DONE.
REQ-014 IDLE: start=1 and abort=0 -> DRIVE; idx := 0; table := 8'h00; mismatch := 0.
REQ-015 DRIVE: one cycle; {a,b,c} := idx; next SETTLE, or CAPTURE when SETTLE=0.
REQ-016 SETTLE: stay exactly SETTLE cycles (down-counter, width sized for 15), then CAPTURE.
REQ-017 CAPTURE: table[idx] := f_in; idx=7 -> DONE; else idx := idx+1 and -> DRIVE.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-019 Each vector SHALL take SETTLE+2 cycles; done SHALL be high in the cycle after edge 8*(SETTLE+2), counting the start-sampling edge as edge 0.
REQ-020 {a,b,c} SHALL hold the current vector through SETTLE and CAPTURE, and SHALL hold the last value in IDLE.
REQ-021 start while busy SHALL be ignored; start asserted in the DONE cycle SHALL NOT be accepted.
REQ-022 abort=1 in any non-IDLE state SHALL force IDLE at the next edge; done is not pulsed; table keeps bits captured so far.
REQ-023 start and abort both high in IDLE: abort wins and the block stays in IDLE.
REQ-024 idx SHALL be 3 bits and SHALL never wrap past 7 within a scan.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, idx=0, a=b=c=0, busy=0, done=0, table=8'h00, mismatch=0 and the settle counter to 0, including mid-scan.
REQ-026 After rst_n deasserts, the first start SHALL be accepted no earlier than the next rising edge.

Configuration
REQ-027 Macro TT_COMPARE_EN defined: in DONE, mismatch := (table != golden), held until the next accepted start, abort or reset.
REQ-028 Macro TT_COMPARE_EN undefined: golden unused and mismatch tied to 0.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, DRIVE, SETTLE, CAPTURE, DONE), the NUM_VECTORS=8 constant and the settle counter width.
REQ-030 Sub-module func3_eval SHALL implement the network f = a·b + a·b'·c for bench and top-level use; the scanner SHALL contain no knowledge of the function.

Verification
REQ-031 SETTLE=3, func3_eval on f_in, pulse start -> done after 40 edges; table=8'hE0; busy high for 40 cycles.
REQ-032 TT_COMPARE_EN, golden=8'hE0 -> mismatch=0; golden=8'hE1 -> mismatch=1 from DONE until the next start.
REQ-033 SETTLE=0 -> done after 16 edges; table=8'hE0.
REQ-034 abort in the CAPTURE cycle of vector 5 -> IDLE next edge; no done pulse; table=8'h20; a restarted scan gives 8'hE0.
REQ-035 rst_n low during SETTLE of vector 3 -> all outputs zero immediately; start held high during busy is ignored, and a start/abort collision in IDLE leaves busy=0.

Source files
------------

// File: rtl/truth_table_scanner_pkg.sv
// ============================================================================
// truth_table_scanner_pkg : shared FSM states and sizing for the scanner.  Rev 1.0
// ============================================================================
`default_nettype none

package truth_table_scanner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int NUM_VECTORS  = 8;
  localparam int IDX_W        = $clog2(NUM_VECTORS);
  localparam int SETTLE_CNT_W = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

endpackage

`default_nettype wire

// File: rtl/truth_table_scanner_func3_eval.sv
// ============================================================================
// func3_eval : 3-input network under test, f = a.b + a.b'.c.  Rev 1.0
// ============================================================================
`default_nettype none

module func3_eval (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic f
);

  assign f = (a & b) | (a & ~b & c);

endmodule

`default_nettype wire

// File: rtl/truth_table_scanner.sv
// ============================================================================
// truth_table_scanner : drives all 8 input vectors, captures f_in per vector.
// Optional macro TT_COMPARE_EN enables the golden-table compare.  Rev 1.0
// ============================================================================
`default_nettype none

module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int SETTLE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       f_in,
  input  logic [7:0] golden,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  // Captured table; the name "table" itself is a reserved word.
  output logic [7:0] tt_table,
  output logic       mismatch
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE);
  localparam logic [SETTLE_CNT_W-1:0] CNT_ONE     = SETTLE_CNT_W'(1);

  state_t                  state;
  state_t                  state_d;
  logic [IDX_W-1:0]        idx;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic                    accept;

  assign accept = start && !abort;
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:    if (accept) state_d = ST_DRIVE;
      ST_DRIVE:   if (abort)                 state_d = ST_IDLE;
                  else if (SETTLE == 0)      state_d = ST_CAPTURE;
                  else                       state_d = ST_SETTLE;
      ST_SETTLE:  if (abort)                 state_d = ST_IDLE;
                  else if (settle_cnt <= CNT_ONE) state_d = ST_CAPTURE;
      ST_CAPTURE: if (abort)                 state_d = ST_IDLE;
                  else if (idx == LAST_IDX)  state_d = ST_DONE;
                  else                       state_d = ST_DRIVE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // The capture happens even on an aborted CAPTURE cycle so that bits seen so far are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      settle_cnt <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      c          <= 1'b0;
      tt_table   <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            idx      <= '0;
            tt_table <= 8'h00;
          end
        end
        ST_DRIVE: begin
          {a, b, c}  <= idx;
          settle_cnt <= SETTLE_LOAD;
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt - CNT_ONE;
        end
        ST_CAPTURE: begin
          tt_table[idx] <= f_in;
          if (!abort && (idx != LAST_IDX)) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef TT_COMPARE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (accept) mismatch <= 1'b0;
    end else if (abort) begin
      mismatch <= 1'b0;
    end else if (state == ST_DONE) begin
      mismatch <= (tt_table != golden);
    end
  end
`else
  logic unused_golden;
  assign unused_golden = ^golden;
  assign mismatch      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_truth_table_scanner.sv
// ============================================================================
// tb_truth_table_scanner : directed self-checking bench for the scanner.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_truth_table_scanner;

`ifdef TT_COMPARE_EN
  localparam logic CMP = 1'b1;
`else
  localparam logic CMP = 1'b0;
`endif

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic       abort  = 1'b0;
  logic       start0 = 1'b0;
  logic       abort0 = 1'b0;
  logic [7:0] golden = 8'hE0;

  logic       a, b, c, f_in, busy, done, mismatch;
  logic [7:0] tt_table;
  logic       a0, b0, c0, f_in0, busy0, done0, mismatch0;
  logic [7:0] tt_table0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  func3_eval u_f  (.a(a),  .b(b),  .c(c),  .f(f_in));
  func3_eval u_f0 (.a(a0), .b(b0), .c(c0), .f(f_in0));

  truth_table_scanner #(.SETTLE(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f_in(f_in),
    .golden(golden), .a(a), .b(b), .c(c), .busy(busy), .done(done),
    .tt_table(tt_table), .mismatch(mismatch)
  );

  truth_table_scanner #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .f_in(f_in0),
    .golden(golden), .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0),
    .tt_table(tt_table0), .mismatch(mismatch0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full scan on the SETTLE=3 instance; optionally keeps start high the whole time.
  task automatic run_scan(input bit hold, input logic exp_mm);
    int edges;
    int bc;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    edges = 0;
    bc    = 0;
    while (!done && edges < 200) begin
      if (busy) bc++;
      tick();
      edges++;
    end
    check("done_edge", edges, 40);
    check("table", tt_table, 8'hE0);
    check("busy_cycles", bc, 40);
    tick();
    start = 1'b0;
    check("post_busy", busy, 0);
    check("post_done", done, 0);
    check("mismatch", mismatch, exp_mm);
  endtask

  initial begin
    int edges;
    bit saw_done;

    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_abc", {a, b, c}, 3'b000);
    check("rst_table", tt_table, 8'h00);
    check("rst_mismatch", mismatch, 0);
    check("rst_busy0", busy0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic scan with a start pulse.
    golden = 8'hE0;
    run_scan(1'b0, 1'b0);

    // start held through the scan and its DONE cycle; golden differs in bit 0.
    golden = 8'hE1;
    run_scan(1'b1, CMP);
    tick();
    tick();
    check("mm_hold", mismatch, CMP);
    golden = 8'hE0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mm_clear", mismatch, 0);
    check("restart_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_drive_busy", busy, 0);

    // Abort in the CAPTURE cycle of vector 5.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (29) tick();
    check("abc_v5", {a, b, c}, 3'b101);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_table", tt_table, 8'h20);
    check("abort_abc_hold", {a, b, c}, 3'b101);
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    run_scan(1'b0, 1'b0);

    // Asynchronous reset in the SETTLE phase of vector 3.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
    check("abc_v3", {a, b, c}, 3'b011);
    check("v3_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_abc", {a, b, c}, 3'b000);
    check("mid_rst_table", tt_table, 8'h00);
    check("mid_rst_mismatch", mismatch, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);

    // start and abort together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    check("collide_busy_a", busy, 0);
    tick();
    check("collide_busy_b", busy, 0);
    start = 1'b0;
    abort = 1'b0;

    // SETTLE=0 instance.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    edges = 0;
    while (!done0 && edges < 200) begin
      tick();
      edges++;
    end
    check("s0_done_edge", edges, 16);
    check("s0_table", tt_table0, 8'hE0);
    tick();
    check("s0_post_busy", busy0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
